// File: rtl/seq_sum_product_pkg.sv
// Shared definitions for the handshaked sum/product unit.
// The state encodings are also used by the bench for direct state checks.
package seq_sum_product_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_sum_product_shift_add_mul.sv
// Iterative shift-add multiplier: consumes one multiplier bit per clock and
// finishes exactly WIDTH edges after start.
module shift_add_mul #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [CW-1:0]      cnt;

    assign acc_next = b_sh[0] ? (acc + a_sh) : acc;
    assign done     = busy && (cnt == CW'(WIDTH - 1));
    // Valid only while done is high; the caller registers it on that edge.
    assign product  = acc_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy <= 1'b0;
            a_sh <= '0;
            b_sh <= '0;
            acc  <= '0;
            cnt  <= '0;
        end else if (start) begin
            busy <= 1'b1;
            a_sh <= {{WIDTH{1'b0}}, a};
            b_sh <= b;
            acc  <= '0;
            cnt  <= '0;
        end else if (busy) begin
            acc  <= acc_next;
            a_sh <= a_sh << 1;
            b_sh <= b_sh >> 1;
            cnt  <= cnt + CW'(1);
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/seq_sum_product.sv
// Handshaked arithmetic unit: registered a+b and iterative a*b, plus a
// saturating count of completed result handshakes.
module seq_sum_product
    import seq_sum_product_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH:0]     sum,
    output logic [2*WIDTH-1:0] product,
    output logic [CNT_W-1:0]   txn_count
);

    state_t             state;
    state_t             state_nxt;
    logic               accept;
    logic               zero_op;
    logic               mul_start;
    logic               mul_busy;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;

    assign accept    = in_valid && in_ready;
    assign zero_op   = (a == '0) || (b == '0);
    assign mul_start = accept && !zero_op;

    shift_add_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = zero_op ? DONE : BUSY;
                end
            end
            BUSY: begin
                // Losing the multiplier while BUSY can only come from an upset;
                // fall back to IDLE rather than wait forever.
                if (mul_done) begin
                    state_nxt = DONE;
                end else if (!mul_busy) begin
                    state_nxt = IDLE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum       <= '0;
            product   <= '0;
            txn_count <= '0;
        end else begin
            if (accept) begin
                sum <= {1'b0, a} + {1'b0, b};
                if (zero_op) begin
                    product <= '0;
                end
            end
            if (mul_done && state == BUSY) begin
                product <= mul_product;
            end
            if (out_valid && out_ready && (txn_count != {CNT_W{1'b1}})) begin
                txn_count <= txn_count + CNT_W'(1);
            end
        end
    end

endmodule
